// File: rtl/mips_write_checker_pkg.sv
// Shared types and helpers for the topMips data-memory write checker.
package mips_chk_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_PASS    = 3'd2,
        S_FAIL    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_t;

    // Number of bits needed to index 'value' distinct items (ceil(log2(value))).
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mips_write_checker_if.sv
// Host/bench side of the write checker: expected-store loading, topMips snoop
// signals and the status outputs.
interface mips_write_checker_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             clear;
    logic             start;
    logic             exp_valid;
    logic             exp_ready;
    logic [WIDTH-1:0] exp_adr;
    logic [WIDTH-1:0] exp_data;
    logic             memwrite;
    logic [WIDTH-1:0] adr;
    logic [WIDTH-1:0] writedata;
    logic             busy;
    logic             pass;
    logic             fail;
    logic             timeout;
    logic [CNT_W-1:0] match_count;
    logic [CNT_W-1:0] mismatch_count;
    logic [WIDTH-1:0] bad_adr;
    logic [WIDTH-1:0] bad_data;

    // Host / bench view: drives control, expected entries and the snooped bus.
    modport master (
        output clear, start, exp_valid, exp_adr, exp_data, memwrite, adr, writedata,
        input  exp_ready, busy, pass, fail, timeout, match_count, mismatch_count,
               bad_adr, bad_data
    );

    // Checker view.
    modport slave (
        input  clear, start, exp_valid, exp_adr, exp_data, memwrite, adr, writedata,
        output exp_ready, busy, pass, fail, timeout, match_count, mismatch_count,
               bad_adr, bad_data
    );
endinterface

// File: rtl/mips_write_checker_fifo.sv
// In-order queue of expected stores with synchronous flush and a
// combinational head for same-cycle comparison.
module chk_fifo
    import mips_chk_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush_i,
    input  logic                    push_i,
    input  logic [W-1:0]            push_data_i,
    input  logic                    pop_i,
    output logic [W-1:0]            head_o,
    output logic                    empty_o,
    output logic                    full_o,
    output logic [clog2(DEPTH):0]   count_o
);
    localparam int AW = clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; an entry is never read before it has been written.
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;

endmodule

// File: rtl/mips_write_checker.sv
// Snoops the topMips data-memory write port and checks each store against an
// in-order queue of expected (address, data) pairs.
module mips_write_checker
    import mips_chk_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int STRICT         = 0,
    parameter int STOP_ON_FAIL   = 1,
    parameter int CNT_W          = 8
) (
    input  logic          clk,
    input  logic          reset,
    mips_write_checker_if.slave bus
);
    localparam int AW = clog2(DEPTH);
    localparam int TW = clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_q, state_d;
    logic [TW-1:0]      cyc_q, cyc_d, cyc_inc;
    logic [CNT_W-1:0]   match_q, match_d;
    logic [CNT_W-1:0]   mism_q, mism_d;
    logic [WIDTH-1:0]   bad_adr_q, bad_adr_d;
    logic [WIDTH-1:0]   bad_data_q, bad_data_d;

    logic [2*WIDTH-1:0] head;
    logic [WIDTH-1:0]   head_adr, head_data;
    logic               empty, full;
    logic [AW:0]        count;
    logic               push, qualified, is_match, mismatch_ev, last_pop, any_mismatch;

    assign head_adr      = head[2*WIDTH-1:WIDTH];
    assign head_data     = head[WIDTH-1:0];
    assign bus.exp_ready = (state_q == S_IDLE) && !full;
    assign push          = bus.exp_valid && bus.exp_ready;

    chk_fifo #(.W(2 * WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (bus.clear),
        .push_i      (push),
        .push_data_i ({bus.exp_adr, bus.exp_data}),
        .pop_i       (qualified),
        .head_o      (head),
        .empty_o     (empty),
        .full_o      (full),
        .count_o     (count)
    );

    // Store qualification and comparison against the current queue head.
    always_comb begin
        qualified    = (state_q == S_RUN) && bus.memwrite && !empty &&
                       ((STRICT != 0) || (bus.adr == head_adr));
        is_match     = (bus.adr == head_adr) && (bus.writedata == head_data);
        mismatch_ev  = qualified && !is_match;
        last_pop     = qualified && (count == (AW+1)'(1));
        any_mismatch = (mism_q != '0) || mismatch_ev;
        cyc_inc      = cyc_q + TW'(1);
    end

    // FSM next state, counters and first-mismatch capture.
    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        match_d    = match_q;
        mism_d     = mism_q;
        bad_adr_d  = bad_adr_q;
        bad_data_d = bad_data_q;
        if (bus.clear) begin
            state_d    = S_IDLE;
            cyc_d      = '0;
            match_d    = '0;
            mism_d     = '0;
            bad_adr_d  = '0;
            bad_data_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_d = S_RUN;
                        cyc_d   = '0;
                    end
                end
                S_RUN: begin
                    cyc_d = cyc_inc;
                    if (qualified && is_match && (match_q != CNT_MAX))
                        match_d = match_q + CNT_W'(1);
                    if (mismatch_ev) begin
                        if (mism_q != CNT_MAX) mism_d = mism_q + CNT_W'(1);
                        if (mism_q == '0) begin
                            bad_adr_d  = bus.adr;
                            bad_data_d = bus.writedata;
                        end
                    end
                    // A store that empties the queue outranks a timeout on the same edge.
                    if (mismatch_ev && (STOP_ON_FAIL != 0))
                        state_d = S_FAIL;
                    else if (empty || last_pop)
                        state_d = any_mismatch ? S_FAIL : S_PASS;
                    else if (cyc_inc == TW'(TIMEOUT_CYCLES))
                        state_d = S_TIMEOUT;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // State and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cyc_q      <= '0;
            match_q    <= '0;
            mism_q     <= '0;
            bad_adr_q  <= '0;
            bad_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            match_q    <= match_d;
            mism_q     <= mism_d;
            bad_adr_q  <= bad_adr_d;
            bad_data_q <= bad_data_d;
        end
    end

    assign bus.busy           = (state_q == S_RUN);
    assign bus.pass           = (state_q == S_PASS);
    assign bus.fail           = (state_q == S_FAIL);
    assign bus.timeout        = (state_q == S_TIMEOUT);
    assign bus.match_count    = match_q;
    assign bus.mismatch_count = mism_q;
    assign bus.bad_adr        = bad_adr_q;
    assign bus.bad_data       = bad_data_q;

endmodule

// File: tb/tb_mips_write_checker.sv
// Bench for mips_write_checker: three instances (STRICT=0/STOP=1, STRICT=1/STOP=1,
// STRICT=0/STOP=0) share one stimulus stream so their behaviour can be contrasted.
module tb_mips_write_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clear = 1'b0, start = 1'b0, exp_valid = 1'b0, memwrite = 1'b0;
    logic [7:0] exp_adr = '0, exp_data = '0, adr = '0, writedata = '0;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    mips_write_checker_if #(.WIDTH(8), .CNT_W(8)) if_a ();
    mips_write_checker_if #(.WIDTH(8), .CNT_W(8)) if_b ();
    mips_write_checker_if #(.WIDTH(8), .CNT_W(8)) if_c ();

    assign if_a.clear = clear;  assign if_a.start = start;  assign if_a.exp_valid = exp_valid;
    assign if_a.exp_adr = exp_adr;  assign if_a.exp_data = exp_data;
    assign if_a.memwrite = memwrite;  assign if_a.adr = adr;  assign if_a.writedata = writedata;
    assign if_b.clear = clear;  assign if_b.start = start;  assign if_b.exp_valid = exp_valid;
    assign if_b.exp_adr = exp_adr;  assign if_b.exp_data = exp_data;
    assign if_b.memwrite = memwrite;  assign if_b.adr = adr;  assign if_b.writedata = writedata;
    assign if_c.clear = clear;  assign if_c.start = start;  assign if_c.exp_valid = exp_valid;
    assign if_c.exp_adr = exp_adr;  assign if_c.exp_data = exp_data;
    assign if_c.memwrite = memwrite;  assign if_c.adr = adr;  assign if_c.writedata = writedata;

    mips_write_checker #(.WIDTH(8), .DEPTH(4), .TIMEOUT_CYCLES(100), .STRICT(0),
                         .STOP_ON_FAIL(1), .CNT_W(8))
        dut_a (.clk(clk), .reset(reset), .bus(if_a));
    mips_write_checker #(.WIDTH(8), .DEPTH(4), .TIMEOUT_CYCLES(100), .STRICT(1),
                         .STOP_ON_FAIL(1), .CNT_W(8))
        dut_b (.clk(clk), .reset(reset), .bus(if_b));
    mips_write_checker #(.WIDTH(8), .DEPTH(4), .TIMEOUT_CYCLES(100), .STRICT(0),
                         .STOP_ON_FAIL(0), .CNT_W(8))
        dut_c (.clk(clk), .reset(reset), .bus(if_c));

    typedef struct {
        logic [7:0] ea, ed, sa, sd;
        logic       a_pass, a_fail, a_busy;
        logic [7:0] a_match, a_mism, a_bad_adr, a_bad_data;
        logic       b_fail;
        logic [7:0] b_bad_adr;
        logic       c_fail;
    } vec_t;

    typedef struct {
        logic       busy, pass, fail;
        logic [7:0] match, mism;
    } obs_t;

    vec_t vecs[5];
    obs_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] d);
        exp_valid = 1'b1; exp_adr = a; exp_data = d; tick(); exp_valid = 1'b0;
    endtask

    task automatic start_run();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic store(input logic [7:0] a, input logic [7:0] d);
        memwrite = 1'b1; adr = a; writedata = d; tick(); memwrite = 1'b0;
    endtask

    function automatic obs_t observe(input int which);
        obs_t o;
        case (which)
            0: o = '{if_a.busy, if_a.pass, if_a.fail, if_a.match_count, if_a.mismatch_count};
            1: o = '{if_b.busy, if_b.pass, if_b.fail, if_b.match_count, if_b.mismatch_count};
            default: o = '{if_c.busy, if_c.pass, if_c.fail, if_c.match_count, if_c.mismatch_count};
        endcase
        return o;
    endfunction

    // Drive one store, queue its expected outcome, then pop and compare once the flags settle.
    task automatic store_sb(input int which, input string tag, input logic [7:0] a,
                            input logic [7:0] d, input obs_t expect_o);
        obs_t exp_o, got;
        sb.push_back(expect_o);
        store(a, d);
        got   = observe(which);
        exp_o = sb.pop_front();
        check({tag, " busy"},  32'(got.busy),  32'(exp_o.busy));
        check({tag, " pass"},  32'(got.pass),  32'(exp_o.pass));
        check({tag, " fail"},  32'(got.fail),  32'(exp_o.fail));
        check({tag, " match"}, 32'(got.match), 32'(exp_o.match));
        check({tag, " mism"},  32'(got.mism),  32'(exp_o.mism));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int accepted;
        // Reset state.
        #1 reset = 1'b1;
        tick(); tick();
        check("rst busy", 32'(if_a.busy), 0);
        check("rst pass", 32'(if_a.pass), 0);
        check("rst fail", 32'(if_a.fail), 0);
        check("rst timeout", 32'(if_a.timeout), 0);
        check("rst match", 32'(if_a.match_count), 0);
        check("rst bad_adr", 32'(if_a.bad_adr), 0);
        check("rst exp_ready", 32'(if_a.exp_ready), 1);
        reset = 1'b0;
        tick();

        // Single-entry vectors: expected entry, one store, outcome per instance.
        vecs[0] = '{8'hFF, 8'h0D, 8'hFF, 8'h0D, 1, 0, 0, 8'd1, 8'd0, 8'h00, 8'h00, 0, 8'h00, 0};
        vecs[1] = '{8'hFF, 8'h0D, 8'hFF, 8'h0C, 0, 1, 0, 8'd0, 8'd1, 8'hFF, 8'h0C, 1, 8'hFF, 1};
        vecs[2] = '{8'hFF, 8'h0D, 8'h80, 8'h05, 0, 0, 1, 8'd0, 8'd0, 8'h00, 8'h00, 1, 8'h80, 0};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0, 8'd1, 8'd0, 8'h00, 8'h00, 0, 8'h00, 0};
        vecs[4] = '{8'h5A, 8'hA5, 8'h5A, 8'h5A, 0, 1, 0, 8'd0, 8'd1, 8'h5A, 8'h5A, 1, 8'h5A, 1};
        for (int i = 0; i < 5; i++) begin
            do_clear();
            load(vecs[i].ea, vecs[i].ed);
            start_run();
            store(vecs[i].sa, vecs[i].sd);
            check($sformatf("v%0d a.pass", i), 32'(if_a.pass), 32'(vecs[i].a_pass));
            check($sformatf("v%0d a.fail", i), 32'(if_a.fail), 32'(vecs[i].a_fail));
            check($sformatf("v%0d a.busy", i), 32'(if_a.busy), 32'(vecs[i].a_busy));
            check($sformatf("v%0d a.match", i), 32'(if_a.match_count), 32'(vecs[i].a_match));
            check($sformatf("v%0d a.mism", i), 32'(if_a.mismatch_count), 32'(vecs[i].a_mism));
            check($sformatf("v%0d a.bad_adr", i), 32'(if_a.bad_adr), 32'(vecs[i].a_bad_adr));
            check($sformatf("v%0d a.bad_data", i), 32'(if_a.bad_data), 32'(vecs[i].a_bad_data));
            check($sformatf("v%0d b.fail", i), 32'(if_b.fail), 32'(vecs[i].b_fail));
            check($sformatf("v%0d b.bad_adr", i), 32'(if_b.bad_adr), 32'(vecs[i].b_bad_adr));
            check($sformatf("v%0d c.fail", i), 32'(if_c.fail), 32'(vecs[i].c_fail));
        end

        // Non-matching address ignored when STRICT=0, checked when STRICT=1.
        do_clear();
        load(8'hFF, 8'h0D);
        start_run();
        store(8'h10, 8'h01);
        check("ign a.busy", 32'(if_a.busy), 1);
        check("ign a.match", 32'(if_a.match_count), 0);
        check("ign b.fail", 32'(if_b.fail), 1);
        check("ign b.bad_adr", 32'(if_b.bad_adr), 32'h10);
        store(8'hFF, 8'h0D);
        check("ign a.pass", 32'(if_a.pass), 1);
        check("ign a.match2", 32'(if_a.match_count), 1);
        check("ign a.mism", 32'(if_a.mismatch_count), 0);
        check("ign b.fail sticky", 32'(if_b.fail), 1);

        // Clear wipes flags, counters and the captured bad store.
        do_clear();
        check("clr b.fail", 32'(if_b.fail), 0);
        check("clr b.bad_adr", 32'(if_b.bad_adr), 0);
        check("clr b.bad_data", 32'(if_b.bad_data), 0);
        check("clr b.mism", 32'(if_b.mismatch_count), 0);
        check("clr a.pass", 32'(if_a.pass), 0);

        // Start with an empty queue passes on the following cycle.
        start_run();
        check("empty busy", 32'(if_a.busy), 1);
        tick();
        check("empty pass", 32'(if_a.pass), 1);

        // Timeout lands exactly TIMEOUT_CYCLES after the start edge.
        do_clear();
        load(8'hFF, 8'h0D);
        start_run();
        for (int i = 0; i < 99; i++) tick();
        check("to early", 32'(if_a.timeout), 0);
        check("to early busy", 32'(if_a.busy), 1);
        tick();
        check("to timeout", 32'(if_a.timeout), 1);
        check("to pass", 32'(if_a.pass), 0);
        check("to fail", 32'(if_a.fail), 0);
        check("to busy", 32'(if_a.busy), 0);
        check("to exp_ready", 32'(if_a.exp_ready), 0);
        start_run();
        check("to start ignored", 32'(if_a.timeout), 1);

        // Fill a DEPTH=4 queue while exp_valid is held for 6 cycles.
        do_clear();
        accepted = 0;
        exp_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_adr  = 8'h20 + 8'(i);
            exp_data = 8'h30 + 8'(i);
            check($sformatf("fill ready%0d", i), 32'(if_a.exp_ready), (i < 4) ? 1 : 0);
            if (if_a.exp_ready) accepted++;
            tick();
        end
        exp_valid = 1'b0;
        check("fill accepted", 32'(accepted), 4);
        start_run();
        for (int i = 0; i < 4; i++)
            store_sb(0, $sformatf("fill st%0d", i), 8'h20 + 8'(i), 8'h30 + 8'(i),
                     '{(i < 3), (i == 3), 1'b0, 8'(i + 1), 8'd0});

        // STOP_ON_FAIL=0 keeps checking through a bad middle store.
        do_clear();
        load(8'h40, 8'h01);
        load(8'h41, 8'h02);
        load(8'h42, 8'h03);
        start_run();
        store_sb(2, "sof st0", 8'h40, 8'h01, '{1'b1, 1'b0, 1'b0, 8'd1, 8'd0});
        store_sb(2, "sof st1", 8'h41, 8'hFF, '{1'b1, 1'b0, 1'b0, 8'd1, 8'd1});
        check("sof a.fail early", 32'(if_a.fail), 1);
        store_sb(2, "sof st2", 8'h42, 8'h03, '{1'b0, 1'b0, 1'b1, 8'd2, 8'd1});
        check("sof c.bad_adr", 32'(if_c.bad_adr), 32'h41);
        check("sof c.bad_data", 32'(if_c.bad_data), 32'hFF);

        // Reset mid-RUN acts without waiting for a clock edge.
        do_clear();
        load(8'h50, 8'h01);
        load(8'h51, 8'h02);
        start_run();
        store(8'h50, 8'h01);
        check("mr pre busy", 32'(if_a.busy), 1);
        check("mr pre match", 32'(if_a.match_count), 1);
        #2 reset = 1'b1;
        #1;
        check("mr busy", 32'(if_a.busy), 0);
        check("mr match", 32'(if_a.match_count), 0);
        check("mr exp_ready", 32'(if_a.exp_ready), 1);
        reset = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mips_write_checker.md
Name: mips_write_checker

Overview:
- Synthesizable, parametrised self-checking monitor for the topMips data-memory write port. It replaces ad-hoc benches that compare one hard-coded store.
- Holds an in-order queue of expected (address, data) stores, loaded by the bench or host.
- Compares observed stores against the queue head and reports pass / fail / timeout, plus match and mismatch counts and details of the first bad store.
- Sits beside topMips, snooping memwrite/adr/writedata; usable in simulation and on FPGA with status on LEDs.

Parameters:
- WIDTH, 8, address and data width of the monitored bus.
- DEPTH, 8, expected-store queue entries (power of 2, >=2).
- TIMEOUT_CYCLES, 1000, cycles allowed in RUN before TIMEOUT (>=1).
- STRICT, 0: 0 = only stores whose adr equals the head entry's address are checked, others ignored; 1 = every store is checked.
- STOP_ON_FAIL, 1: 1 = first mismatch ends the run; 0 = keep checking to the end.
- CNT_W, 8, width of the match and mismatch counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush: empty queue, zero counters, go to IDLE.
- start  in  1  one-cycle pulse to begin checking.
- exp_valid  in  1  expected entry offered.
- exp_ready  out  1  entry accepted when exp_valid & exp_ready.
- exp_adr  in  WIDTH  expected store address.
- exp_data  in  WIDTH  expected store data.
- memwrite  in  1  topMips store strobe.
- adr  in  WIDTH  topMips memory address.
- writedata  in  WIDTH  topMips store data.
- busy  out  1  in RUN.
- pass  out  1  sticky, all expected stores matched.
- fail  out  1  sticky, mismatch detected.
- timeout  out  1  sticky, RUN exceeded TIMEOUT_CYCLES.
- match_count  out  CNT_W  matched stores.
- mismatch_count  out  CNT_W  mismatched stores.
- bad_adr  out  WIDTH  address of the first mismatch.
- bad_data  out  WIDTH  data of the first mismatch.

Behaviour:
- Reset (asynchronous): state IDLE, queue empty, all counters 0, busy/pass/fail/timeout 0, bad_adr/bad_data 0. This applies at any point, including mid-RUN.
- States and transitions:
  - IDLE -> RUN on start.
  - RUN -> PASS when the queue empties with mismatch_count == 0.
  - RUN -> FAIL on a mismatch if STOP_ON_FAIL = 1; otherwise when the queue empties with mismatch_count > 0.
  - RUN -> TIMEOUT when the cycle counter reaches TIMEOUT_CYCLES with the queue non-empty.
  - PASS, FAIL and TIMEOUT are terminal until clear or reset.
- Loading:
  - exp_ready = (state == IDLE) & !full.
  - In RUN or a terminal state exp_valid is ignored.
  - An entry is written at the posedge where exp_valid & exp_ready; full is asserted after DEPTH entries.
- start with an empty queue: PASS on the next cycle.
- start outside IDLE: ignored.
- Store sampling: at each posedge in RUN with memwrite = 1, compare adr/writedata with the queue head, using the combinational head.
  - Qualification: STRICT = 0 qualifies only when adr == head address; STRICT = 1 qualifies every store.
  - A qualified store pops the head.
  - Match: match_count + 1.
  - Mismatch: mismatch_count + 1. bad_adr/bad_data are captured only on the first mismatch.
  - Flags update one cycle after the deciding store.
- Counters saturate at 2^CNT_W - 1.
- Cycle counter: zeroed on entry to RUN, increments every RUN cycle. At equality with TIMEOUT_CYCLES the block enters TIMEOUT, unless the same edge pops the last entry, in which case pass/fail wins.
- clear:
  - Priority: reset > clear > start.
  - Empties the queue and zeroes counters and flags.
  - bad_adr/bad_data return to 0.
- busy = (state == RUN).

Decomposition:
- Package mips_chk_pkg:
  - state encoding (S_IDLE, S_RUN, S_PASS, S_FAIL, S_TIMEOUT);
  - a clog2 helper for the DEPTH pointers and the TIMEOUT_CYCLES counter width.
- Sub-module chk_fifo (WIDTH*2 wide, DEPTH deep, synchronous flush, full/empty flags, pointer wrap-around). The top holds the FSM, counters and comparator.

Test Plan:
- WIDTH=8. Load (FF,0D), start. Stores (10,01),(FF,0D) with STRICT=0 -> (10,01) ignored; pass=1 one cycle after the FF store; match_count=1, mismatch_count=0.
- Load (FF,0D), start, store (FF,0C) -> fail=1; bad_adr=FF; bad_data=0C; mismatch_count=1; busy=0.
- STRICT=1, load (FF,0D), store (80,05) -> fail=1, bad_adr=80. The same stimulus with STRICT=0 -> no fail.
- TIMEOUT_CYCLES=100, load (FF,0D), start, no stores -> timeout=1 exactly 100 cycles after start; pass=0, fail=0.
- DEPTH=4, hold exp_valid for 6 cycles -> 4 accepted; exp_ready=0 from the 5th. After 4 matching stores -> pass. A reset asserted mid-RUN clears all outputs immediately, without waiting for clk.
- STOP_ON_FAIL=0, load 3 entries with the 2nd wrong -> remains busy through the 3rd store, then fail=1, match_count=2, mismatch_count=1.
